serial_alu_seq: RTL and testbench

Bit-serial sequencer that drives the team's combinational 1-bit ALU slice from the controlling side. It accepts WIDTH-bit operands and a 2-bit opcode, and presents one operand bit pair per clock to the slice. It chains the slice's z output back into cin for add, and assembles the returned y bits into a WIDTH-bit result plus a status flag. It sits between the datapath register file and one external 1-bit slice, which gives N-bit operations at one slice of area cost.

---
 rtl/serial_alu_seq.sv | 121 ++++++++++++
 tb/tb_serial_alu_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/serial_alu_seq.sv
// Bit-serial sequencer driving an external 1-bit ALU slice: feeds one operand bit pair per
// clock, chains carry through the slice for add, and assembles the returned bits LSB first.
module serial_alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             flag,
   output logic             slice_a,
   output logic             slice_b,
   output logic             slice_cin,
   output logic             slice_c0,
   output logic             slice_c1,
   input  logic             slice_y,
   input  logic             slice_z
);

   localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_CMP = 2'b11;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] a_reg, a_next;
   logic [WIDTH-1:0] b_reg, b_next;
   logic [1:0]       op_reg, op_next;
   logic             carry_reg, carry_next;
   logic             acc_ne_reg, acc_ne_next;
   logic [IW-1:0]    idx_reg, idx_next;
   logic [WIDTH-1:0] result_reg, result_next;
   logic             flag_reg, flag_next;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         a_reg      <= '0;
         b_reg      <= '0;
         op_reg     <= '0;
         carry_reg  <= 1'b0;
         acc_ne_reg <= 1'b0;
         idx_reg    <= '0;
         result_reg <= '0;
         flag_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         a_reg      <= a_next;
         b_reg      <= b_next;
         op_reg     <= op_next;
         carry_reg  <= carry_next;
         acc_ne_reg <= acc_ne_next;
         idx_reg    <= idx_next;
         result_reg <= result_next;
         flag_reg   <= flag_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      a_next      = a_reg;
      b_next      = b_reg;
      op_next     = op_reg;
      carry_next  = carry_reg;
      acc_ne_next = acc_ne_reg;
      idx_next    = idx_reg;
      result_next = result_reg;
      flag_next   = flag_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               a_next      = a;
               b_next      = b;
               op_next     = op;
               carry_next  = (op == OP_ADD) ? cin : 1'b0;
               acc_ne_next = 1'b0;
               idx_next    = '0;
               result_next = '0;
               flag_next   = 1'b0;
               state_next  = RUN;
            end
         end
         RUN: begin
            result_next = {slice_y, result_reg[WIDTH-1:1]};
            a_next      = a_reg >> 1;
            b_next      = b_reg >> 1;
            if (op_reg == OP_ADD) carry_next = slice_z;
            if (op_reg == OP_CMP) acc_ne_next = acc_ne_reg | slice_z;
            idx_next = idx_reg + IW'(1);
            if (idx_reg == LAST_IDX) begin
               // Flag captures the post-update carry / inequality on the final bit.
               if (op_reg == OP_ADD)      flag_next = carry_next;
               else if (op_reg == OP_CMP) flag_next = acc_ne_next;
               else                       flag_next = 1'b0;
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign busy      = (state_reg != IDLE);
   assign done      = (state_reg == DONE);
   assign result    = result_reg;
   assign flag      = flag_reg;
   assign slice_a   = (state_reg == RUN) & a_reg[0];
   assign slice_b   = (state_reg == RUN) & b_reg[0];
   assign slice_cin = (state_reg == RUN) & carry_reg;
   assign slice_c0  = (state_reg == RUN) & op_reg[0];
   assign slice_c1  = (state_reg == RUN) & op_reg[1];

endmodule

// File: tb/tb_serial_alu_seq.sv
// Directed bench for serial_alu_seq with a behavioural 1-bit ALU slice on the slice ports.
module tb_serial_alu_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [1:0] op;
   logic [7:0] a, b;
   logic       cin;
   logic       busy, done, flag;
   logic [7:0] result;
   logic       slice_a, slice_b, slice_cin, slice_c0, slice_c1, slice_y, slice_z;

   int pass_cnt = 0;
   int check_cnt = 0;

   always #5 clk = ~clk;

   serial_alu_seq #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .result(result), .flag(flag),
      .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
      .slice_c0(slice_c0), .slice_c1(slice_c1), .slice_y(slice_y), .slice_z(slice_z)
   );

   // 1-bit slice: add, and, not-a, compare (y=0, z=a^b).
   always_comb begin
      slice_y = 1'b0;
      slice_z = 1'b0;
      case ({slice_c1, slice_c0})
         2'b00: begin
            slice_y = slice_a ^ slice_b ^ slice_cin;
            slice_z = (slice_a & slice_b) | (slice_cin & (slice_a ^ slice_b));
         end
         2'b01: slice_y = slice_a & slice_b;
         2'b10: slice_y = ~slice_a;
         default: slice_z = slice_a ^ slice_b;
      endcase
   end

   task automatic idle_cycle();
      @(posedge clk);
      #1;
   endtask

   // Issues one op and returns at #1 inside the done cycle (or after the cycle budget).
   task automatic run_op(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                         input logic ci, output int cyc);
      op = o; a = x; b = y; cin = ci; start = 1'b1;
      cyc = 0;
      do begin
         @(posedge clk);
         #1;
         start = 1'b0;
         cyc++;
      end while (!done && cyc < 30);
      $display("op=%b a=%h b=%h cin=%b -> result=%h flag=%b done=%b cycles=%0d",
               o, x, y, ci, result, flag, done, cyc);
   endtask

   task automatic check_op(input string name, input int cyc, input logic [7:0] exp_res,
                           input logic exp_flag);
      check_cnt++;
      if (done !== 1'b1 || cyc != 9) $display("FAIL %s_latency got done=%b cycles=%0d want done=1 cycles=9", name, done, cyc);
      else pass_cnt++;
      check_cnt++;
      if (result !== exp_res) $display("FAIL %s_result got %h want %h", name, result, exp_res);
      else pass_cnt++;
      check_cnt++;
      if (flag !== exp_flag) $display("FAIL %s_flag got %b want %b", name, flag, exp_flag);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0; cin = 1'b0;
      repeat (2) idle_cycle();
      check_cnt++;
      if ({busy, done, flag, result} !== 11'd0) $display("FAIL reset_state got busy=%b done=%b flag=%b result=%h want all 0", busy, done, flag, result);
      else pass_cnt++;
      check_cnt++;
      if ({slice_a, slice_b, slice_cin, slice_c0, slice_c1} !== 5'b0) $display("FAIL reset_slice got %b want 00000", {slice_a, slice_b, slice_cin, slice_c0, slice_c1});
      else pass_cnt++;
      rst_n = 1'b1;
      idle_cycle();
   endtask

   task automatic test_add();
      int cyc;
      run_op(2'b00, 8'h5A, 8'hC3, 1'b0, cyc);
      check_op("add1", cyc, 8'h1D, 1'b1);
      idle_cycle();
      run_op(2'b00, 8'h01, 8'hFF, 1'b1, cyc);
      check_op("add2", cyc, 8'h01, 1'b1);
      idle_cycle();
   endtask

   task automatic test_logic();
      int cyc;
      run_op(2'b01, 8'hF0, 8'h3C, 1'b1, cyc);
      check_op("and", cyc, 8'h30, 1'b0);
      idle_cycle();
      run_op(2'b10, 8'h5A, 8'hFF, 1'b0, cyc);
      check_op("not", cyc, 8'hA5, 1'b0);
      idle_cycle();
   endtask

   task automatic test_compare();
      int cyc;
      run_op(2'b11, 8'h12, 8'h12, 1'b0, cyc);
      check_op("cmp_eq", cyc, 8'h00, 1'b0);
      idle_cycle();
      run_op(2'b11, 8'h12, 8'h92, 1'b0, cyc);
      check_op("cmp_msb", cyc, 8'h00, 1'b1);
      idle_cycle();
   endtask

   task automatic test_start_while_busy();
      int cyc;
      int pulses;
      op = 2'b00; a = 8'h7F; b = 8'h01; cin = 1'b0; start = 1'b1;
      cyc = 0; pulses = 0;
      for (int i = 0; i < 14; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         if (done) begin
            pulses++;
            check_cnt++;
            if (result !== 8'h80 || flag !== 1'b0 || cyc != 9) $display("FAIL busy_start_result got %h flag=%b at cycle %0d want 80 flag=0 at 9", result, flag, cyc);
            else pass_cnt++;
         end
         // Extra requests during run cycles 2..6 with different operands.
         if (cyc >= 1 && cyc <= 5) begin
            start = 1'b1; a = 8'h00; b = 8'h00;
         end else begin
            start = 1'b0;
         end
      end
      $display("busy-start add 7f+01 -> done pulses=%0d result=%h flag=%b", pulses, result, flag);
      check_cnt++;
      if (pulses != 1) $display("FAIL busy_start_pulses got %0d want 1", pulses);
      else pass_cnt++;
      check_cnt++;
      if (busy !== 1'b0) $display("FAIL busy_start_idle got busy=%b want 0", busy);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_run();
      int cyc;
      op = 2'b00; a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
      idle_cycle();
      start = 1'b0;
      repeat (3) idle_cycle();
      rst_n = 1'b0;
      idle_cycle();
      rst_n = 1'b1;
      $display("reset mid-run -> busy=%b done=%b result=%h flag=%b", busy, done, result, flag);
      check_cnt++;
      if ({busy, done, flag, result} !== 11'd0) $display("FAIL midrun_reset_state got busy=%b done=%b flag=%b result=%h want all 0", busy, done, flag, result);
      else pass_cnt++;
      check_cnt++;
      if ({slice_a, slice_b, slice_cin, slice_c0, slice_c1} !== 5'b0) $display("FAIL midrun_reset_slice got %b want 00000", {slice_a, slice_b, slice_cin, slice_c0, slice_c1});
      else pass_cnt++;
      idle_cycle();
      check_cnt++;
      if (done !== 1'b0) $display("FAIL midrun_no_done got %b want 0", done);
      else pass_cnt++;
      run_op(2'b00, 8'h10, 8'h20, 1'b0, cyc);
      check_op("after_reset", cyc, 8'h30, 1'b0);
      idle_cycle();
   endtask

   task automatic test_back_to_back();
      int cyc;
      run_op(2'b01, 8'hF0, 8'h3C, 1'b0, cyc);
      check_op("b2b_first", cyc, 8'h30, 1'b0);
      idle_cycle();
      check_cnt++;
      if (result !== 8'h30 || busy !== 1'b0) $display("FAIL b2b_hold got result=%h busy=%b want 30 busy=0", result, busy);
      else pass_cnt++;
      run_op(2'b00, 8'h5A, 8'hC3, 1'b1, cyc);
      check_op("b2b_second", cyc, 8'h1E, 1'b1);
      idle_cycle();
   endtask

   initial begin
      test_reset();
      test_add();
      test_logic();
      test_compare();
      test_start_while_busy();
      test_reset_mid_run();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
